// File: rtl/icache_refill.sv
// Instruction-cache refill engine: on a miss, fetch the 8-word block holding
// the missing PC (critical word first, wrap order), gather the beats, then
// present them to the cache until it acknowledges the write.
module icache_refill #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss,
    input  logic [31:0] miss_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        update,
    output logic [31:0] update_cache_0,
    output logic [31:0] update_cache_1,
    output logic [31:0] update_cache_2,
    output logic [31:0] update_cache_3,
    output logic [31:0] update_cache_4,
    output logic [31:0] update_cache_5,
    output logic [31:0] update_cache_6,
    output logic [31:0] update_cache_7,
    input  logic        cache_update_occured,
    output logic        refill_busy,
    output logic        refill_done,
    output logic        refill_err
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, UPDATE} state_t;

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [2:0]  cnt;
    logic [15:0] tmo;
    logic [31:0] beat [8];
    logic        progress;
    logic        done_d;
    logic        err_d;

    // Outputs are decoded from state or taken straight from registers, so no
    // input ever reaches an output combinationally.
    assign mem_req     = (state == REQ);
    assign update      = (state == UPDATE);
    assign refill_busy = (state != IDLE);
    assign mem_addr    = {pc_q[31:2], 2'b00};

    assign update_cache_0 = beat[0];
    assign update_cache_1 = beat[1];
    assign update_cache_2 = beat[2];
    assign update_cache_3 = beat[3];
    assign update_cache_4 = beat[4];
    assign update_cache_5 = beat[5];
    assign update_cache_6 = beat[6];
    assign update_cache_7 = beat[7];

    // State register plus registered completion/abort pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            refill_done <= done_d;
            refill_err  <= err_d;
        end
    end

    // Next-state decode; progress wins over an expiring timeout.
    always_comb begin
        state_nxt = state;
        progress  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (miss) state_nxt = REQ;
            end
            REQ: begin
                progress = mem_ack;
                if (mem_ack) begin
                    state_nxt = FILL;
                end else if (tmo == TMO_LIM) begin
                    state_nxt = IDLE;
                    err_d     = 1'b1;
                end
            end
            FILL: begin
                progress = mem_rvalid;
                if (mem_rvalid) begin
                    if (cnt == 3'd7) state_nxt = UPDATE;
                end else if (tmo == TMO_LIM) begin
                    state_nxt = IDLE;
                    err_d     = 1'b1;
                end
            end
            UPDATE: begin
                if (cache_update_occured) begin
                    state_nxt = IDLE;
                    done_d    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Miss PC latch, beat counter and no-progress timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            cnt  <= '0;
            tmo  <= '0;
        end else begin
            if (state == IDLE && miss) begin
                pc_q <= miss_pc;
                cnt  <= '0;
                tmo  <= '0;
            end
            if (state == REQ || state == FILL) begin
                tmo <= progress ? 16'd0 : tmo + 16'd1;
            end
            if (state == FILL && mem_rvalid) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Beat capture in arrival order; an aborted refill discards its beats.
    always_ff @(posedge clk) begin
        if (reset || err_d) begin
            for (int i = 0; i < 8; i++) beat[i] <= '0;
        end else if (state == FILL && mem_rvalid) begin
            beat[cnt] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: expected beats are queued as they are
// driven and compared when the cache update is presented.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss, miss_t;
    logic [31:0] miss_pc;
    logic        mem_ack, mem_rvalid, cache_update_occured;
    logic [31:0] mem_rdata;

    logic        mem_req, update, refill_busy, refill_done, refill_err;
    logic [31:0] mem_addr;
    logic [31:0] uc [8];

    logic        mem_req_t, update_t, refill_busy_t, refill_done_t, refill_err_t;
    logic [31:0] mem_addr_t;
    logic [31:0] uct [8];

    int checks = 0;
    int errors = 0;
    int upd_rises = 0;
    int err_seen = 0;
    logic [31:0] exp_q [$];
    logic [31:0] held [8];
    logic        prev_upd = 1'b0;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_pc(miss_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .update(update),
        .update_cache_0(uc[0]), .update_cache_1(uc[1]), .update_cache_2(uc[2]),
        .update_cache_3(uc[3]), .update_cache_4(uc[4]), .update_cache_5(uc[5]),
        .update_cache_6(uc[6]), .update_cache_7(uc[7]),
        .cache_update_occured(cache_update_occured), .refill_busy(refill_busy),
        .refill_done(refill_done), .refill_err(refill_err)
    );

    icache_refill #(.TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset), .miss(miss_t), .miss_pc(miss_pc),
        .mem_req(mem_req_t), .mem_addr(mem_addr_t), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .update(update_t),
        .update_cache_0(uct[0]), .update_cache_1(uct[1]), .update_cache_2(uct[2]),
        .update_cache_3(uct[3]), .update_cache_4(uct[4]), .update_cache_5(uct[5]),
        .update_cache_6(uct[6]), .update_cache_7(uct[7]),
        .cache_update_occured(cache_update_occured), .refill_busy(refill_busy_t),
        .refill_done(refill_done_t), .refill_err(refill_err_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare on the rising edge of update, then hold-check.
    always @(negedge clk) begin
        if (refill_err) err_seen++;
        if (update && !prev_upd) begin
            upd_rises++;
            for (int k = 0; k < 8; k++) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("beat%0d", k), uc[k], exp_q.pop_front());
                end
                held[k] = uc[k];
            end
        end else if (update) begin
            for (int k = 0; k < 8; k++) chk($sformatf("hold%0d", k), uc[k], held[k]);
        end
        prev_upd = update;
    end

    // Drive beats per an rvalid pattern (LSB first); gaps carry junk data.
    task automatic beats(input logic [31:0] base, input logic [15:0] pat, input int n,
                         input logic miss_noise);
        int b;
        b = 0;
        for (int i = 0; i < n; i++) begin
            chk("upd_early", {31'd0, update}, 32'd0);
            mem_rvalid = pat[i];
            miss       = miss_noise;
            miss_pc    = $urandom;
            if (pat[i]) begin
                mem_rdata = base + 32'(b);
                exp_q.push_back(base + 32'(b));
                b++;
            end else begin
                mem_rdata = $urandom;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        miss       = 1'b0;
        chk("upd_after_last", {31'd0, update}, 32'd1);
    endtask

    task automatic start(input logic [31:0] pc, input int ack_delay);
        miss    = 1'b1;
        miss_pc = pc;
        tick();
        miss    = 1'b0;
        chk("req", {31'd0, mem_req}, 32'd1);
        chk("addr", mem_addr, {pc[31:2], 2'b00});
        chk("busy", {31'd0, refill_busy}, 32'd1);
        for (int i = 0; i < ack_delay; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 + 32'(i);
            miss_pc    = $urandom;
            tick();
            chk("req_hold", {31'd0, mem_req}, 32'd1);
            chk("addr_hold", mem_addr, {pc[31:2], 2'b00});
        end
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic finish_update(input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            chk("upd_wait", {31'd0, update}, 32'd1);
        end
        cache_update_occured = 1'b1;
        tick();
        cache_update_occured = 1'b0;
        chk("upd_fall", {31'd0, update}, 32'd0);
        chk("done", {31'd0, refill_done}, 32'd1);
        chk("busy_fall", {31'd0, refill_busy}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, refill_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; miss = 1'b0; miss_t = 1'b0; miss_pc = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; cache_update_occured = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_upd", {31'd0, update}, 32'd0);
        chk("rst_busy", {31'd0, refill_busy}, 32'd0);
        chk("rst_done", {31'd0, refill_done}, 32'd0);
        chk("rst_err", {31'd0, refill_err}, 32'd0);
        chk("rst_uc0", uc[0], 32'd0);

        // Back-to-back refill: update lands 10 cycles after the miss edge.
        start(32'h0000_1234, 0);
        beats(32'h0000_00A0, 16'h00FF, 8, 1'b0);
        finish_update(2);

        // rvalid in IDLE must not start anything.
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick(); tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid", {31'd0, refill_busy}, 32'd0);

        // Delayed ack with rvalid noise in REQ, gapped beats, miss noise in FILL/UPDATE.
        start(32'h0000_2008, 4);
        beats(32'h1111_0000, 16'b0000_0111_1101_1001, 11, 1'b1);
        miss = 1'b1; miss_pc = 32'h7777_7770;
        tick();
        chk("upd_miss_noise", {31'd0, update}, 32'd1);
        miss = 1'b0;
        finish_update(1);

        // Timeout on the TIMEOUT=4 instance: error 5 cycles into FILL.
        miss_t = 1'b1; miss_pc = 32'h0000_0040;
        tick();
        miss_t = 1'b0;
        chk("t_req", {31'd0, mem_req_t}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t_err%0d", i), {31'd0, refill_err_t}, (i == 5) ? 32'd1 : 32'd0);
            chk("t_upd", {31'd0, update_t}, 32'd0);
        end
        chk("t_idle", {31'd0, refill_busy_t}, 32'd0);
        tick();
        chk("t_err_pulse", {31'd0, refill_err_t}, 32'd0);
        chk("t_upd_never", {31'd0, update_t}, 32'd0);

        // Reset mid-burst after 4 beats, then a clean refill.
        start(32'h0000_3000, 0);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_0000 + 32'(i);
            tick();
        end
        mem_rvalid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, refill_busy}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_uc%0d", k), uc[k], 32'd0);
        start(32'h0000_3010, 0);
        beats(32'h0000_00C0, 16'h00FF, 8, 1'b0);
        finish_update(0);

        // Miss held across two refills; second request uses the PC seen in IDLE.
        miss = 1'b1; miss_pc = 32'h0000_5000;
        tick();
        chk("h_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hE000_0000 + 32'(i);
            exp_q.push_back(32'hE000_0000 + 32'(i));
            tick();
        end
        mem_rvalid = 1'b0;
        chk("h_upd", {31'd0, update}, 32'd1);
        miss_pc = 32'h0000_6004;
        cache_update_occured = 1'b1;
        tick();
        cache_update_occured = 1'b0;
        chk("h_done", {31'd0, refill_done}, 32'd1);
        tick();
        chk("h_req2", {31'd0, mem_req}, 32'd1);
        chk("h_addr2", mem_addr, 32'h0000_6004);
        chk("h_done_pulse", {31'd0, refill_done}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hF000_0000 + 32'(i);
            exp_q.push_back(32'hF000_0000 + 32'(i));
            tick();
        end
        mem_rvalid = 1'b0;
        miss = 1'b0;
        finish_update(1);

        // Reset wins over a same-cycle cache acknowledge.
        start(32'h0000_8000, 0);
        beats(32'h0000_0D00, 16'h00FF, 8, 1'b0);
        reset = 1'b1; cache_update_occured = 1'b1;
        tick();
        reset = 1'b0; cache_update_occured = 1'b0;
        chk("rst_cuo_done", {31'd0, refill_done}, 32'd0);
        chk("rst_cuo_upd", {31'd0, update}, 32'd0);
        chk("rst_cuo_uc7", uc[7], 32'd0);
        tick();
        chk("rst_cuo_done2", {31'd0, refill_done}, 32'd0);

        chk("upd_rises", 32'(upd_rises), 32'd6);
        chk("main_err", 32'(err_seen), 32'd0);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
